aes128_inv_cipher_ctrl: RTL and testbench
=========================================

# aes128_inv_cipher_ctrl

Iterative AES-128 decryption sequencer. It accepts one 128-bit ciphertext block over a valid/ready handshake and drives one inverse round per clock through a shared combinational inverse-round datapath built on the existing InvMixColumns block. It fetches round keys from an external precomputed key-schedule store and returns the plaintext over a second valid/ready handshake. It sits between the block-level stream interface and the decryption datapath in the decryption/ tree.

## Interface
- NR, 10, number of AES rounds; fixed at 10 for AES-128; the round-key address width is derived as 4 bits.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext block present on in_data.
- in_ready  output  1  controller can accept a block.
- in_data  input  128  ciphertext block, byte 0 in bits [127:120].
- key_ready  input  1  key-schedule store holds a complete, stable set of round keys 0..10.
- rk_addr  output  4  round-key index requested this cycle.
- rk_data  input  128  round key for rk_addr, returned combinationally in the same cycle.
- out_valid  output  1  plaintext on out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  plaintext block.
- busy  output  1  a block is in flight (ROUND or FINAL state).

## Operation
- States: IDLE, ROUND, FINAL, DONE. Encoding is 2-bit binary.
- IDLE:
  - in_ready = key_ready; rk_addr = 10.
  - On in_valid && in_ready: state_reg <= in_data ^ rk_data (the initial AddRoundKey), round_ctr <= 9, and the FSM moves to ROUND.
- ROUND:
  - rk_addr = round_ctr.
  - state_reg <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk_data)).
  - If round_ctr == 1, go to FINAL; otherwise round_ctr <= round_ctr - 1.
- FINAL:
  - rk_addr = 0.
  - state_reg <= AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk_data), with no InvMixColumns.
  - Go to DONE.
- DONE:
  - out_valid = 1; out_data = state_reg; rk_addr = 10.
  - On out_ready, go to IDLE. No new block is accepted in the same cycle.
- in_ready is 0 in ROUND, FINAL and DONE. in_valid is ignored outside IDLE.
- A key_ready drop while busy is not detected. The key store must hold its keys stable from accept until out_valid && out_ready.
- out_data is valid only while out_valid is high. Between blocks it shows the live state_reg.
- Reset (any state, including mid-round): state becomes IDLE, round_ctr = 0, state_reg = 0, out_valid = 0, busy = 0. in_ready then follows key_ready on the first cycle after reset.

## Timing
- Reset values:
  - in_ready = key_ready (combinational, IDLE).
  - out_valid = 0, busy = 0, out_data = 0, rk_addr = 10.
- Latency: the accept edge at cycle T gives out_valid = 1 from cycle T+11. The sequence is nine ROUND cycles (T+1..T+9) and one FINAL cycle (T+10).
- out_valid and out_data are held unchanged until the out_ready handshake. If out_ready is already high on arrival, out_valid lasts exactly one cycle.
- Minimum block-to-block interval: 12 cycles (accept, 10 rounds, DONE, with IDLE re-entered on the cycle after the handshake).
- busy is high exactly in cycles T+1..T+10.
- All outputs except in_ready and rk_addr are registered or state-decoded. rk_addr is a pure function of state and round_ctr.

## Structure
- Shared header aes_defs.vh holds:
  - NR, the state encodings IDLE/ROUND/FINAL/DONE, and the 128-bit block width.
  - The byte-order convention, shared with the encryption side.
- Sub-module inv_round (combinational), covering InvShiftRows, InvSubBytes, AddRoundKey and an optional InvMixColumns:
  - Inputs: state, round_key, last.
  - Output: next_state.
  - It instantiates the existing InvMixColumns, and the controller instantiates it exactly once.
- The controller itself holds only the FSM, round_ctr, state_reg and the handshake logic.

## Test plan
- FIPS-197 C.1: keys expanded from 000102030405060708090a0b0c0d0e0f, in_data = 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data = 00112233445566778899aabbccddeeff, with out_valid rising exactly 11 cycles after accept.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, in_data = 3925841d02dc09fbdc118597196a0b32 -> out_data = 3243f6a8885a308d313198a2e0370734. rk_addr sequence from accept is 10,9,8,...,1,0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> out_valid and out_data stay stable, and in_ready = 0 throughout despite in_valid = 1. After the handshake, in_ready = 1 on the next cycle.
- Back-to-back: C.1 then Appendix B ciphertext with in_valid held high and out_ready = 1 -> both plaintexts are correct and the accept edges are 12 cycles apart.
- Reset at ROUND with round_ctr = 5 -> next cycle shows IDLE, busy = 0, out_valid = 0, out_data = 0. A following C.1 block then decrypts correctly.
- key_ready = 0 with in_valid = 1 -> in_ready = 0 and no accept. Raising key_ready accepts in that same cycle.

Source files
------------

// File: rtl/aes128_inv_cipher_ctrl_pkg.sv
// Shared definitions for the iterative AES-128 decryption sequencer.
//   - Round count, block width, round-key address width and state encodings.
//   - Byte order: byte 0 of a block sits in bits [127:120]. Byte i holds row (i % 4)
//     and column (i / 4), which matches the encryption side.
//   - GF(2^8) helpers used by the inverse-round datapath.
package aes128_inv_cipher_ctrl_pkg;

    localparam int NR    = 10;
    localparam int BLK_W = 128;
    localparam int RK_AW = 4;

    localparam logic [RK_AW-1:0] RK_LAST  = RK_AW'(NR);
    localparam logic [RK_AW-1:0] RK_FIRST = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254. Zero maps to zero, which AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map, then take the field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] t;
        t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        return {gf_mul(8'h0e, s0) ^ gf_mul(8'h0b, s1) ^ gf_mul(8'h0d, s2) ^ gf_mul(8'h09, s3),
                gf_mul(8'h09, s0) ^ gf_mul(8'h0e, s1) ^ gf_mul(8'h0b, s2) ^ gf_mul(8'h0d, s3),
                gf_mul(8'h0d, s0) ^ gf_mul(8'h09, s1) ^ gf_mul(8'h0e, s2) ^ gf_mul(8'h0b, s3),
                gf_mul(8'h0b, s0) ^ gf_mul(8'h0d, s1) ^ gf_mul(8'h09, s2) ^ gf_mul(8'h0e, s3)};
    endfunction

endpackage

// File: rtl/aes128_inv_cipher_ctrl_if.sv
// Handshake and key-store bundle of the decryption sequencer.
//   in_valid/in_ready/in_data     ciphertext stream in
//   key_ready/rk_addr/rk_data     round-key store lookup (combinational return)
//   out_valid/out_ready/out_data  plaintext stream out
//   busy                          a block is being processed
// slave  : the controller side
// master : the surrounding stream / key-store side
interface aes128_inv_cipher_ctrl_if;
    import aes128_inv_cipher_ctrl_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             key_ready;
    logic [RK_AW-1:0] rk_addr;
    logic [BLK_W-1:0] rk_data;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_data;
    logic             busy;

    modport slave (
        input  in_valid, in_data, key_ready, rk_data, out_ready,
        output in_ready, rk_addr, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, key_ready, rk_data, out_ready,
        input  in_ready, rk_addr, out_valid, out_data, busy
    );

endinterface

// File: rtl/aes128_inv_cipher_ctrl_inv_round.sv
// Combinational AES inverse round and the InvMixColumns block it uses.
//   aes128_inv_cipher_ctrl_inv_round:
//     state      in   128  current cipher state
//     round_key  in   128  round key for this round
//     last       in   1    final round: skip InvMixColumns
//     next_state out  128  InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state))))
//   aes128_inv_cipher_ctrl_inv_mix_columns:
//     data_in    in   128  four columns
//     data_out   out  128  InvMixColumns of data_in
module aes128_inv_cipher_ctrl_inv_mix_columns
    import aes128_inv_cipher_ctrl_pkg::*;
(
    input  logic [BLK_W-1:0] data_in,
    output logic [BLK_W-1:0] data_out
);

    always_comb begin
        data_out = '0;
        for (int c = 0; c < 4; c++) begin
            data_out[127-32*c -: 32] = inv_mix_column(data_in[127-32*c -: 32]);
        end
    end

endmodule

module aes128_inv_cipher_ctrl_inv_round
    import aes128_inv_cipher_ctrl_pkg::*;
(
    input  logic [BLK_W-1:0] state,
    input  logic [BLK_W-1:0] round_key,
    input  logic             last,
    output logic [BLK_W-1:0] next_state
);

    logic [BLK_W-1:0] shifted;
    logic [BLK_W-1:0] subbed;
    logic [BLK_W-1:0] keyed;
    logic [BLK_W-1:0] mixed;

    // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4].
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shifted[127-8*(r+4*c) -: 8] = state[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
    end

    always_comb begin
        subbed = '0;
        for (int i = 0; i < 16; i++) begin
            subbed[127-8*i -: 8] = inv_sbox(shifted[127-8*i -: 8]);
        end
    end

    assign keyed = subbed ^ round_key;

    aes128_inv_cipher_ctrl_inv_mix_columns u_inv_mix_columns (
        .data_in  (keyed),
        .data_out (mixed)
    );

    assign next_state = last ? keyed : mixed;

endmodule

// File: rtl/aes128_inv_cipher_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock through a
// single shared inverse-round datapath, round keys fetched from an external store.
//   clk  in  single clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  slave modport of aes128_inv_cipher_ctrl_if (stream in, key lookup,
//        stream out, busy)
//
// state | meaning
// IDLE  | waiting for a ciphertext block; in_ready follows key_ready
// ROUND | inverse round with InvMixColumns, key round_ctr (9 down to 1)
// FINAL | last inverse round without InvMixColumns, key 0
// DONE  | plaintext held on out_data until out_ready
module aes128_inv_cipher_ctrl
    import aes128_inv_cipher_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    aes128_inv_cipher_ctrl_if.slave  bus
);

    ctrl_state_e      state;
    ctrl_state_e      state_nxt;
    logic [RK_AW-1:0] round_ctr;
    logic [RK_AW-1:0] round_ctr_nxt;
    logic [BLK_W-1:0] state_reg;
    logic [BLK_W-1:0] state_reg_nxt;
    logic [BLK_W-1:0] round_out;
    logic             last_round;

    assign last_round = (state == FINAL);

    aes128_inv_cipher_ctrl_inv_round u_inv_round (
        .state      (state_reg),
        .round_key  (bus.rk_data),
        .last       (last_round),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_ctr <= '0;
            state_reg <= '0;
        end else begin
            state     <= state_nxt;
            round_ctr <= round_ctr_nxt;
            state_reg <= state_reg_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        round_ctr_nxt = round_ctr;
        state_reg_nxt = state_reg;
        bus.rk_addr   = RK_LAST;
        bus.in_ready  = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = bus.key_ready;
                if (bus.in_valid && bus.key_ready) begin
                    state_reg_nxt = bus.in_data ^ bus.rk_data;
                    round_ctr_nxt = RK_LAST - 1'b1;
                    state_nxt     = ROUND;
                end
            end
            ROUND: begin
                bus.rk_addr   = round_ctr;
                state_reg_nxt = round_out;
                if (round_ctr == RK_AW'(1)) begin
                    state_nxt = FINAL;
                end else begin
                    round_ctr_nxt = round_ctr - 1'b1;
                end
            end
            FINAL: begin
                bus.rk_addr   = RK_FIRST;
                state_reg_nxt = round_out;
                state_nxt     = DONE;
            end
            DONE: begin
                // Return to IDLE first; a new block is never taken on the handshake cycle.
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == ROUND) || (state == FINAL);
    assign bus.out_data  = state_reg;

endmodule

// File: tb/tb_aes128_inv_cipher_ctrl.sv
// Directed bench for aes128_inv_cipher_ctrl using the FIPS-197 vectors. The bench
// acts as the key-schedule store, expanding each cipher key itself.
module tb_aes128_inv_cipher_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   sel = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   acc_q[$];

    logic [127:0] ks [0:1][0:10];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    aes128_inv_cipher_ctrl_if bif();

    aes128_inv_cipher_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    assign bif.rk_data = (bif.rk_addr <= 4'd10) ? ks[sel][bif.rk_addr] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bif.in_valid && bif.in_ready) acc_q.push_back(cyc);
    end

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: field inverse followed by the affine map.
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = tb_gmul(p, p);
            r = tb_gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input int s, input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = tb_gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[s][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a block from IDLE and follows it through every round to the handshake.
    task automatic run_block(input string name, input logic [127:0] ct, input int s,
                             input logic [127:0] pt, input int hold, input bit keep_valid);
        sel          = s;
        bif.in_data  = ct;
        bif.in_valid = 1'b1;
        #1;
        chk({name, "_in_ready_idle"}, bif.in_ready, 1);
        chk({name, "_rk_addr_idle"}, bif.rk_addr, 10);
        step();
        if (!keep_valid) bif.in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("%s_rk_addr_%0d", name, k), bif.rk_addr, 10 - k);
            chk($sformatf("%s_busy_%0d", name, k), bif.busy, 1);
            chk($sformatf("%s_out_valid_early_%0d", name, k), bif.out_valid, 0);
            chk($sformatf("%s_in_ready_busy_%0d", name, k), bif.in_ready, 0);
            step();
        end
        for (int h = 0; h <= hold; h++) begin
            chk($sformatf("%s_out_valid_%0d", name, h), bif.out_valid, 1);
            chk($sformatf("%s_out_data_%0d", name, h), bif.out_data, pt);
            chk($sformatf("%s_busy_done_%0d", name, h), bif.busy, 0);
            chk($sformatf("%s_in_ready_done_%0d", name, h), bif.in_ready, 0);
            if (h == hold) bif.out_ready = 1'b1;
            step();
        end
        bif.out_ready = 1'b0;
        bif.in_valid  = 1'b0;
        chk({name, "_out_valid_after"}, bif.out_valid, 0);
        chk({name, "_in_ready_after"}, bif.in_ready, 1);
    endtask

    task automatic wait_out_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bif.out_valid) seen = 1'b1;
            else step();
        end
        chk({name, "_out_valid_seen"}, seen, 1);
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.key_ready = 1'b1;
        bif.out_ready = 1'b0;
        expand(0, KEY_C1);
        expand(1, KEY_B);

        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", bif.out_valid, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_out_data", bif.out_data, 0);
        chk("rst_rk_addr", bif.rk_addr, 10);
        chk("rst_in_ready", bif.in_ready, 1);

        // key_ready low blocks acceptance; raising it accepts in that cycle.
        bif.key_ready = 1'b0;
        bif.in_valid  = 1'b1;
        bif.in_data   = CT_C1;
        sel           = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("kr_in_ready_%0d", i), bif.in_ready, 0);
            step();
            chk($sformatf("kr_busy_%0d", i), bif.busy, 0);
        end
        bif.key_ready = 1'b1;
        run_block("c1", CT_C1, 0, PT_C1, 0, 1'b0);

        run_block("appb", CT_B, 1, PT_B, 0, 1'b0);

        run_block("bp", CT_C1, 0, PT_C1, 5, 1'b1);

        // Back-to-back with in_valid and out_ready held high.
        acc_q.delete();
        sel           = 0;
        bif.in_data   = CT_C1;
        bif.in_valid  = 1'b1;
        bif.out_ready = 1'b1;
        step();
        wait_out_valid("b2b1");
        chk("b2b1_out_data", bif.out_data, PT_C1);
        step();
        sel         = 1;
        bif.in_data = CT_B;
        step();
        bif.in_valid = 1'b0;
        wait_out_valid("b2b2");
        chk("b2b2_out_data", bif.out_data, PT_B);
        step();
        bif.out_ready = 1'b0;
        chk("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() == 2) chk("b2b_interval", acc_q[1] - acc_q[0], 12);

        // Reset in the middle of a block while round_ctr is 5.
        sel          = 0;
        bif.in_data  = CT_C1;
        bif.in_valid = 1'b1;
        step();
        bif.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_rk_addr", bif.rk_addr, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy", bif.busy, 0);
        chk("mid_out_valid", bif.out_valid, 0);
        chk("mid_out_data", bif.out_data, 0);
        chk("mid_rk_addr_idle", bif.rk_addr, 10);
        chk("mid_in_ready", bif.in_ready, 1);
        run_block("post_rst", CT_C1, 0, PT_C1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
